// File: rtl/vpu_layer_pkg.sv
// vpu_layer_pkg: shared types and sizing for the sprite layer renderer.
// SPRITE_HFLIP_EN adds the per-slot horizontal-mirror bit to the attribute struct.
package vpu_layer_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned N_SPR    = 8;
  localparam int unsigned SPR_W    = 16;
  localparam int unsigned AW       = 16;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCAN,
    FETCH
  } layer_state_t;

  typedef struct packed {
    logic          en;
`ifdef SPRITE_HFLIP_EN
    logic          hflip;
`endif
    logic [9:0]    x;
    logic [9:0]    y;
    logic [AW-1:0] base;
  } spr_attr_t;

endpackage

// File: rtl/layer_line_buffer.sv
// layer_line_buffer: two line banks, one render write port, one registered display read port.
// A non-requested read cycle returns 24'h0 so the output is transparent when idle.
module layer_line_buffer
  import vpu_layer_pkg::*;
#(
  parameter int unsigned DEPTH = H_ACTIVE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_bank,
  input  logic [9:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic        rd_en,
  input  logic        rd_bank,
  input  logic [9:0]  rd_addr,
  output logic [23:0] rd_data
);

  logic [23:0] mem [2][DEPTH];

  // Render-side write into the selected bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Display-side registered read; transparent when no valid request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_bank][rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: composites up to N_SPR sprites into a double-buffered line.
// Optional feature macro: SPRITE_HFLIP_EN (honour attr_hflip as a horizontal mirror).
module sprite_line_renderer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned N_SPR    = 8,
  parameter int unsigned SPR_W    = 16,
  parameter int unsigned AW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          line_start,
  input  logic [9:0]    line_y,
  input  logic          pix_valid,
  input  logic [9:0]    pix_x,
  input  logic          attr_we,
  input  logic [2:0]    attr_idx,
  input  logic [9:0]    attr_x,
  input  logic [9:0]    attr_y,
  input  logic [AW-1:0] attr_base,
  input  logic          attr_en,
  input  logic          attr_hflip,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [23:0]   mem_rdata,
  output logic [23:0]   pixel_out,
  output logic          busy,
  output logic          overrun
);
  import vpu_layer_pkg::*;

  localparam int unsigned IW = $clog2(N_SPR);
  localparam int unsigned KW = $clog2(SPR_W);

  layer_state_t  state_q, state_d;
  spr_attr_t     attr_q [N_SPR];
  spr_attr_t     snap_q [N_SPR];
  spr_attr_t     cur;
  logic [9:0]    line_y_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [9:0]    clr_q, clr_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] addr_d;
  logic          req_d;
  logic          disp_bank_q;
  logic          hit;
  logic [9:0]    dy;
  logic [10:0]   col;
  logic          wr_en;
  logic [9:0]    wr_addr;
  logic [23:0]   wr_data;

`ifndef SPRITE_HFLIP_EN
  logic unused_hflip;
  assign unused_hflip = attr_hflip;
`endif

  // Host-visible attribute registers; only the enables need a reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_SPR; i++) attr_q[i].en <= 1'b0;
    end else if (attr_we) begin
      attr_q[attr_idx].en   <= attr_en;
      attr_q[attr_idx].x    <= attr_x;
      attr_q[attr_idx].y    <= attr_y;
      attr_q[attr_idx].base <= attr_base;
`ifdef SPRITE_HFLIP_EN
      attr_q[attr_idx].hflip <= attr_hflip;
`endif
    end
  end

  // Freeze attributes and line number for the whole render at line_start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_SPR; i++) snap_q[i].en <= 1'b0;
    end else if (line_start) begin
      snap_q   <= attr_q;
      line_y_q <= line_y;
    end
  end

  // Geometry of the slot under test: vertical hit, bitmap row, target column.
  always_comb begin
    cur = snap_q[idx_q];
    hit = cur.en && ({1'b0, line_y_q} >= {1'b0, cur.y})
                 && ({1'b0, line_y_q} <= ({1'b0, cur.y} + 11'(SPR_W - 1)));
    dy  = line_y_q - cur.y;
    col = {1'b0, cur.x} + 11'(k_q);
`ifdef SPRITE_HFLIP_EN
    if (cur.hflip) col = {1'b0, cur.x} + 11'(SPR_W - 1) - 11'(k_q);
`endif
  end

  // Next-state, memory request and line-buffer write decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_d   = clr_q;
    k_d     = k_q;
    addr_d  = mem_addr;
    req_d   = mem_req;
    wr_en   = 1'b0;
    wr_addr = clr_q;
    wr_data = '0;
    if (line_start) begin
      // Restart wins over everything, including a word acked this same cycle.
      state_d = CLEAR;
      idx_d   = IW'(N_SPR - 1);
      clr_d   = '0;
      k_d     = '0;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        CLEAR: begin
          wr_en = 1'b1;
          clr_d = clr_q + 1'b1;
          if (clr_q == 10'(H_ACTIVE - 1)) state_d = SCAN;
        end
        SCAN: begin
          if (hit) begin
            state_d = FETCH;
            k_d     = '0;
            addr_d  = cur.base + AW'(dy) * AW'(SPR_W);
            req_d   = 1'b1;
          end else if (idx_q == '0) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            wr_en   = (mem_rdata != '0) && (col < 11'(H_ACTIVE));
            wr_addr = col[9:0];
            wr_data = mem_rdata;
            k_d     = k_q + 1'b1;
            addr_d  = mem_addr + 1'b1;
            if (k_q == KW'(SPR_W - 1)) begin
              req_d = 1'b0;
              if (idx_q == '0) begin
                state_d = IDLE;
              end else begin
                state_d = SCAN;
                idx_d   = idx_q - 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters, memory port, bank select and overrun pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      clr_q       <= '0;
      k_q         <= '0;
      mem_addr    <= '0;
      mem_req     <= 1'b0;
      disp_bank_q <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      clr_q       <= clr_d;
      k_q         <= k_d;
      mem_addr    <= addr_d;
      mem_req     <= req_d;
      disp_bank_q <= disp_bank_q ^ line_start;
      overrun     <= line_start && (state_q != IDLE);
    end
  end

  assign busy = (state_q != IDLE);

  layer_line_buffer #(.DEPTH(H_ACTIVE)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_bank (~disp_bank_q),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (pix_valid && (pix_x < 10'(H_ACTIVE))),
    .rd_bank (disp_bank_q),
    .rd_addr (pix_x),
    .rd_data (pixel_out)
  );

endmodule

// File: doc/sprite_line_renderer.md
SPRITE_LINE_RENDERER -- requirements
Module: sprite_line_renderer

Interface
REQ-001 Parameters SHALL be: H_ACTIVE=640 (visible pixels per line); N_SPR=8 (sprite slots); SPR_W=16 (sprite width/height, pixels); AW=16 (memory address width).
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  single system clock
  rst_n  in  1  synchronous active-low reset
  line_start  in  1  one-cycle pulse; begin rendering line line_y
  line_y  in  10  line to render, sampled with line_start
  pix_valid  in  1  display requests a pixel this cycle
  pix_x  in  10  display column, sampled with pix_valid
  attr_we  in  1  sprite attribute write strobe
  attr_idx  in  3  slot written
  attr_x, attr_y  in  10 each  sprite top-left position
  attr_base  in  AW  bitmap base word address
  attr_en  in  1  slot enable
  attr_hflip  in  1  horizontal mirror (used only with SPRITE_HFLIP_EN)
  mem_req  out  1  bitmap read request
  mem_addr  out  AW  bitmap word address, one 24-bit pixel per word
  mem_ack  in  1  word transferred this cycle
  mem_rdata  in  24  pixel, valid when mem_ack=1
  pixel_out  out  24  layer pixel; 24'h000000 = transparent
  busy  out  1  render in progress
  overrun  out  1  one-cycle pulse: line_start arrived while busy
REQ-003 Clock is clk; reset is rst_n, synchronous and active-low.

Function
REQ-004 Two line-buffer banks SHALL exist; on each line_start the display bank and render bank SHALL swap.
REQ-005 FSM states SHALL be IDLE, CLEAR, SCAN, FETCH; line_start from any state -> CLEAR with sprite index = N_SPR-1.
REQ-006 CLEAR SHALL write 24'h0 to render-bank addresses 0..H_ACTIVE-1, one per cycle, then -> SCAN.
REQ-007 SCAN SHALL test slot i for one cycle: attr_en=1 and attr_y <= line_y <= attr_y+SPR_W-1 (11-bit compare, no wrap) -> FETCH; else next slot; after slot 0 -> IDLE.
REQ-008 FETCH SHALL read k=0..SPR_W-1 from mem_addr = attr_base + (line_y-attr_y)*SPR_W + k, modulo 2^AW.
REQ-009 mem_req SHALL stay high with stable mem_addr until mem_ack=1; each mem_ack cycle transfers one word, and mem_addr advances the next cycle.
REQ-010 Word k SHALL be written to render-bank column attr_x+k only if mem_rdata != 24'h0 and attr_x+k < H_ACTIVE; otherwise dropped.
REQ-011 Slots SHALL be processed N_SPR-1 down to 0, so lower index wins overlaps; transparent words never erase.
REQ-012 After word SPR_W-1, FETCH -> SCAN with next slot, or IDLE after slot 0.
REQ-013 pixel_out SHALL be registered: display-bank[pix_x] one cycle after pix_valid=1; 24'h0 one cycle after pix_valid=0 or pix_x >= H_ACTIVE.
REQ-014 busy SHALL be 1 in CLEAR, SCAN, FETCH; 0 in IDLE.
REQ-015 line_start while busy SHALL pulse overrun for one cycle, abandon the render (mem_req drops next cycle, pending word ignored), swap, restart.
REQ-016 Attribute writes SHALL take effect at the next line_start; attributes are snapshotted at line_start.

Reset
REQ-017 rst_n=0 at a clk edge SHALL set: state IDLE, pixel_out 0, mem_req 0, mem_addr 0, busy 0, overrun 0, all attr_en 0, display bank = bank 0.
REQ-018 Line-buffer contents are not reset; a line_start and a full render are required before valid output.

Configuration
REQ-019 With SPRITE_HFLIP_EN defined, attr_hflip=1 SHALL place word k at attr_x+SPR_W-1-k; without it attr_hflip SHALL be ignored and its storage omitted.

Structure
REQ-020 Package vpu_layer_pkg SHALL hold the FSM state enum, H_ACTIVE, N_SPR, SPR_W and the sprite-attribute struct.
REQ-021 Sub-module layer_line_buffer SHALL implement the two banks: one write port (render) and one registered read port (display).

Verification
REQ-022 Slot 0 at (100,50), base 0, opaque 24'hFF0000 data; render line 55 -> addresses 80..95 requested; columns 100..115 read 24'hFF0000, column 99 and 116 read 0.
REQ-023 Slot 3 and slot 1 overlapping at x=200, both on line; slot 1 data 24'h00FF00 -> columns 200..215 show 24'h00FF00.
REQ-024 Sprite at attr_x=630 -> columns 630..639 written, 10 beats stored, 6 dropped, no buffer wrap to column 0.
REQ-025 mem_ack held low 5 cycles per word -> mem_req and mem_addr stable during stalls; result matches REQ-022.
REQ-026 line_start mid-FETCH -> overrun high exactly one cycle, busy stays 1, new render completes correctly.
REQ-027 With SPRITE_HFLIP_EN, hflip=1, word k = k+1 -> column attr_x holds 16, column attr_x+15 holds 1.
